// File: rtl/core_ex_bj_redirect_ctrl.sv
// EX-stage branch/jump redirect sequencer: qualifies taken events, drives the IFU
// redirect handshake, flushes IF/ID and drops wrong-path fetch responses.
module core_ex_bj_redirect_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int OUTST_MAX = 4,
  parameter int OUTST_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_bj,
  input  logic                branch_jump,
  input  logic [PC_WIDTH-1:0] bj_pc,
  output logic                redir_valid,
  input  logic                redir_ready,
  output logic [PC_WIDTH-1:0] redir_pc,
  output logic                flush_if_id,
  input  logic                ifu_req_fire,
  input  logic                ifu_rsp_valid,
  output logic                ifu_rsp_drop,
  output logic                misalign_exc,
  output logic [PC_WIDTH-1:0] misalign_addr,
  output logic [31:0]         bj_cnt,
  output logic [31:0]         taken_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [OUTST_W-1:0] OUTST_LIM = OUTST_W'(OUTST_MAX);
  localparam logic [OUTST_W-1:0] ONE       = OUTST_W'(1);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic [OUTST_W-1:0]    outst_q, outst_d;
  logic [OUTST_W-1:0]    kill_q, kill_d;
  logic                  exc_q, exc_d;
  logic [PC_WIDTH-1:0]   exc_addr_q, exc_addr_d;
  logic [31:0]           bj_cnt_q, bj_cnt_d;
  logic [31:0]           taken_cnt_q, taken_cnt_d;

  logic                  ev_e, ev_t, ev_m;
  logic [OUTST_W-1:0]    outst_next;

  // EX events are only honoured in IDLE; anything seen in REQ/DRAIN is wrong-path.
  assign ev_e = ex_valid & ex_bj & (state_q == IDLE);
  assign ev_t = ev_e & branch_jump;
  assign ev_m = ev_t & (bj_pc[1:0] != 2'b00);

  // Dropped responses still retire an outstanding request.
  assign outst_next = outst_q + OUTST_W'(ifu_req_fire) - OUTST_W'(ifu_rsp_valid);

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    outst_d     = outst_next;
    kill_d      = kill_q;
    exc_d       = 1'b0;
    exc_addr_d  = exc_addr_q;
    bj_cnt_d    = bj_cnt_q;
    taken_cnt_d = taken_cnt_q;
    flush_if_id  = 1'b0;
    ifu_rsp_drop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ev_e) begin
          bj_cnt_d = bj_cnt_q + 32'd1;
        end
        if (ev_m) begin
          exc_d      = 1'b1;
          exc_addr_d = bj_pc;
        end else if (ev_t) begin
          taken_cnt_d = taken_cnt_q + 32'd1;
          flush_if_id = 1'b1;
          redir_pc_d  = bj_pc;
          state_d     = REQ;
        end
      end
      REQ: begin
        flush_if_id  = 1'b1;
        ifu_rsp_drop = ifu_rsp_valid;
        if (redir_ready) begin
          // A request issued in the handshake cycle is still old-path and gets killed.
          kill_d  = outst_next;
          state_d = (outst_next != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        ifu_rsp_drop = ifu_rsp_valid;
        if (ifu_rsp_valid) begin
          kill_d = kill_q - ONE;
          if (kill_q == ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      redir_pc_q  <= '0;
      outst_q     <= '0;
      kill_q      <= '0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
      bj_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      outst_q     <= outst_d;
      kill_q      <= kill_d;
      exc_q       <= exc_d;
      exc_addr_q  <= exc_addr_d;
      bj_cnt_q    <= bj_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign redir_valid   = (state_q == REQ);
  assign redir_pc      = redir_pc_q;
  assign misalign_exc  = exc_q;
  assign misalign_addr = exc_addr_q;
  assign bj_cnt        = bj_cnt_q;
  assign taken_cnt     = taken_cnt_q;

  // The IFU must never exceed its outstanding-request budget.
  a_outst_limit: assert property (@(posedge clk) disable iff (rst) outst_q <= OUTST_LIM);

endmodule

// File: tb/tb_core_ex_bj_redirect_ctrl.sv
// Randomised + directed bench for core_ex_bj_redirect_ctrl against a behavioural
// model built from pending-redirect / kill-count bookkeeping.
module tb_core_ex_bj_redirect_ctrl;

  localparam int PC_WIDTH  = 32;
  localparam int OUTST_MAX = 4;
  localparam int OUTST_W   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                ex_valid, ex_bj, branch_jump;
  logic [PC_WIDTH-1:0] bj_pc;
  logic                redir_valid, redir_ready;
  logic [PC_WIDTH-1:0] redir_pc;
  logic                flush_if_id;
  logic                ifu_req_fire, ifu_rsp_valid, ifu_rsp_drop;
  logic                misalign_exc;
  logic [PC_WIDTH-1:0] misalign_addr;
  logic [31:0]         bj_cnt, taken_cnt;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  // Behavioural model state
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_kill;
  int          m_outst;
  bit          m_exc;
  logic [31:0] m_addr;
  logic [31:0] m_bj;
  logic [31:0] m_taken;

  core_ex_bj_redirect_ctrl #(
    .PC_WIDTH (PC_WIDTH),
    .OUTST_MAX(OUTST_MAX),
    .OUTST_W  (OUTST_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_bj        (ex_bj),
    .branch_jump  (branch_jump),
    .bj_pc        (bj_pc),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .flush_if_id  (flush_if_id),
    .ifu_req_fire (ifu_req_fire),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_drop (ifu_rsp_drop),
    .misalign_exc (misalign_exc),
    .misalign_addr(misalign_addr),
    .bj_cnt       (bj_cnt),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit idle, e, t, mis;
    int on;
    if (rst) begin
      m_pend = 0; m_pc = '0; m_kill = 0; m_outst = 0;
      m_exc = 0; m_addr = '0; m_bj = '0; m_taken = '0;
      return;
    end
    assert (!(ifu_rsp_valid && m_outst == 0)) else $error("protocol: response with nothing outstanding");
    on = m_outst + int'(ifu_req_fire) - int'(ifu_rsp_valid);
    assert (on <= OUTST_MAX) else $error("protocol: outstanding limit exceeded");
    idle = !m_pend && (m_kill == 0);
    e    = ex_valid && ex_bj && idle;
    t    = e && branch_jump;
    mis  = t && (bj_pc[1:0] != 2'b00);
    m_exc = mis;
    if (mis) m_addr = bj_pc;
    if (e) m_bj = m_bj + 32'd1;
    if (t && !mis) begin
      m_taken = m_taken + 32'd1;
      m_pend  = 1;
      m_pc    = bj_pc;
    end else if (m_pend && redir_ready) begin
      m_pend = 0;
      m_kill = on;
    end else if (m_kill > 0 && ifu_rsp_valid) begin
      m_kill--;
    end
    m_outst = on;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit idle, t, mis;
      idle = !m_pend && (m_kill == 0);
      t    = ex_valid && ex_bj && branch_jump && idle;
      mis  = t && (bj_pc[1:0] != 2'b00);
      check("redir_valid",   32'(redir_valid),  32'(m_pend));
      check("redir_pc",      redir_pc,          m_pc);
      check("flush_if_id",   32'(flush_if_id),  32'(m_pend || (t && !mis)));
      check("ifu_rsp_drop",  32'(ifu_rsp_drop), 32'(ifu_rsp_valid && (m_pend || m_kill > 0)));
      check("misalign_exc",  32'(misalign_exc), 32'(m_exc));
      check("misalign_addr", misalign_addr,     m_addr);
      check("bj_cnt",        bj_cnt,            m_bj);
      check("taken_cnt",     taken_cnt,         m_taken);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ex();
    ex_valid = 0; ex_bj = 0; branch_jump = 0; bj_pc = '0;
  endtask

  task automatic drive_ex(input bit taken, input logic [31:0] pc);
    ex_valid = 1; ex_bj = 1; branch_jump = taken; bj_pc = pc;
  endtask

  initial begin
    rst = 1; redir_ready = 0; ifu_req_fire = 0; ifu_rsp_valid = 0;
    clr_ex();
    next_cycle();
    next_cycle();
    rst = 0;
    chk_en = 1;

    $display("test: reset during REQ");
    drive_ex(1, 32'h8000_0100);
    @(negedge clk); check("t1_flush", 32'(flush_if_id), 32'd1);
    next_cycle();
    clr_ex();
    repeat (3) begin
      @(negedge clk); check("t1_req_valid", 32'(redir_valid), 32'd1);
      next_cycle();
    end
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    check("t1_valid_after_rst", 32'(redir_valid), 32'd0);
    check("t1_bj_cnt", bj_cnt, 32'd0);
    check("t1_taken_cnt", taken_cnt, 32'd0);
    check("t1_redir_pc", redir_pc, 32'd0);
    next_cycle();

    $display("test: taken with immediate accept");
    drive_ex(1, 32'h8000_0040);
    redir_ready = 1;
    @(negedge clk);
    check("t2_flush_t", 32'(flush_if_id), 32'd1);
    check("t2_valid_t", 32'(redir_valid), 32'd0);
    next_cycle();
    clr_ex();
    @(negedge clk);
    check("t2_valid_req", 32'(redir_valid), 32'd1);
    check("t2_pc_req", redir_pc, 32'h8000_0040);
    check("t2_flush_req", 32'(flush_if_id), 32'd1);
    next_cycle();
    redir_ready = 0;
    @(negedge clk);
    check("t2_valid_after", 32'(redir_valid), 32'd0);
    check("t2_flush_after", 32'(flush_if_id), 32'd0);
    check("t2_taken_cnt", taken_cnt, 32'd1);
    check("t2_bj_cnt", bj_cnt, 32'd1);
    next_cycle();

    $display("test: backpressure, drain, ignored EX events");
    ifu_req_fire = 1;
    next_cycle();
    next_cycle();
    ifu_req_fire = 0;
    drive_ex(1, 32'h8000_0200);
    next_cycle();
    drive_ex(1, 32'h1234_5678);
    repeat (2) begin
      @(negedge clk); check("t3_pc_hold", redir_pc, 32'h8000_0200);
      next_cycle();
    end
    redir_ready = 1; ifu_req_fire = 1;
    next_cycle();
    redir_ready = 0; ifu_req_fire = 0; ifu_rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("t3_drop", 32'(ifu_rsp_drop), 32'd1);
      next_cycle();
    end
    clr_ex(); ifu_rsp_valid = 0; ifu_req_fire = 1;
    @(negedge clk);
    check("t3_bj_cnt", bj_cnt, 32'd2);
    check("t3_taken_cnt", taken_cnt, 32'd2);
    check("t3_pc_kept", redir_pc, 32'h8000_0200);
    check("t3_valid_idle", 32'(redir_valid), 32'd0);
    next_cycle();
    ifu_req_fire = 0; ifu_rsp_valid = 1;
    @(negedge clk); check("t3_pass", 32'(ifu_rsp_drop), 32'd0);
    next_cycle();
    ifu_rsp_valid = 0;

    $display("test: misaligned taken target");
    drive_ex(1, 32'h8000_0102);
    @(negedge clk); check("t4_flush", 32'(flush_if_id), 32'd0);
    next_cycle();
    clr_ex();
    @(negedge clk);
    check("t4_exc", 32'(misalign_exc), 32'd1);
    check("t4_addr", misalign_addr, 32'h8000_0102);
    check("t4_valid", 32'(redir_valid), 32'd0);
    check("t4_taken_cnt", taken_cnt, 32'd2);
    check("t4_bj_cnt", bj_cnt, 32'd3);
    next_cycle();
    @(negedge clk); check("t4_exc_pulse", 32'(misalign_exc), 32'd0);
    next_cycle();

    $display("test: not-taken with odd target");
    drive_ex(0, 32'h0000_0003);
    @(negedge clk); check("t5_flush", 32'(flush_if_id), 32'd0);
    next_cycle();
    clr_ex();
    @(negedge clk);
    check("t5_exc", 32'(misalign_exc), 32'd0);
    check("t5_bj_cnt", bj_cnt, 32'd4);
    check("t5_taken_cnt", taken_cnt, 32'd2);
    next_cycle();

    $display("test: taken counter wrap");
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    m_taken = 32'hFFFF_FFFF;
    next_cycle();
    release dut.taken_cnt_q;
    drive_ex(1, 32'h8000_0300);
    redir_ready = 1;
    next_cycle();
    clr_ex();
    @(negedge clk);
    check("t6_wrap", taken_cnt, 32'h0000_0000);
    check("t6_valid", 32'(redir_valid), 32'd1);
    next_cycle();
    redir_ready = 0;

    $display("test: randomised traffic");
    for (int n = 0; n < 4000; n++) begin
      bit rsp, fire;
      rst = ($urandom_range(0, 299) == 0);
      ex_valid    = ($urandom_range(0, 2) != 0);
      ex_bj       = ($urandom_range(0, 2) != 0);
      branch_jump = ($urandom_range(0, 1) != 0);
      bj_pc       = $urandom();
      if ($urandom_range(0, 3) != 0) bj_pc[1:0] = 2'b00;
      redir_ready = ($urandom_range(0, 2) == 0);
      rsp  = (m_outst > 0) && ($urandom_range(0, 1) != 0);
      fire = (m_outst - int'(rsp) < OUTST_MAX) && ($urandom_range(0, 1) != 0);
      ifu_rsp_valid = rsp;
      ifu_req_fire  = fire;
      next_cycle();
    end
    rst = 0; redir_ready = 0; ifu_req_fire = 0; ifu_rsp_valid = 0;
    clr_ex();
    next_cycle();
    @(negedge clk);
    chk_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/core_ex_bj_redirect_ctrl.md
Name: core_ex_bj_redirect_ctrl

Overview:
- Sequences the front-end redirect whenever the EX-stage branch/jump unit resolves a taken branch or jump.
- Qualifies the taken event and checks target alignment.
- Holds a valid/ready redirect request to the IFU until accepted.
- Flushes the IF/ID register, then discards stale wrong-path fetch responses still in flight; also keeps branch statistics counters.
- Sits between EX-stage branch resolution, the IFU and the IF/ID pipeline register.

Parameters:
PC_WIDTH, 32, width of PC / redirect target.
OUTST_MAX, 4, maximum IFU fetch requests outstanding at once.
OUTST_W, 3, width of outstanding/kill counters; must hold 0..OUTST_MAX.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX stage holds a valid instruction
ex_bj  in  1  EX instruction is JAL/JALR/Bxx
branch_jump  in  1  resolved taken (from branch/jump decode)
bj_pc  in  PC_WIDTH  resolved target address
redir_valid  out  1  redirect request to IFU
redir_ready  in  1  IFU accepts redirect
redir_pc  out  PC_WIDTH  redirect target
flush_if_id  out  1  invalidate IF/ID register this cycle
ifu_req_fire  in  1  IFU issued a fetch request this cycle
ifu_rsp_valid  in  1  fetch response returned this cycle
ifu_rsp_drop  out  1  discard this cycle's response (wrong path)
misalign_exc  out  1  one-cycle pulse: taken target misaligned
misalign_addr  out  PC_WIDTH  offending target
bj_cnt  out  32  branch/jump instructions resolved
taken_cnt  out  32  taken redirects issued

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high. On rst, all state returns to IDLE on that edge, regardless of state, including mid-REQ or mid-DRAIN, and an asserted redir_valid drops.
- Reset values: redir_valid=0, redir_pc=0, misalign_exc=0, misalign_addr=0, bj_cnt=0, taken_cnt=0, outst=0, kill_cnt=0.
- States: IDLE, REQ, DRAIN.
- Definitions (used below): E = ex_valid & ex_bj & (state==IDLE); T = E & branch_jump; M = T & (bj_pc[1:0]!=0).
- Counters: bj_cnt+=1 on E; taken_cnt+=1 on T & ~M. Both wrap mod 2^32.
- Misaligned target (M):
  - misalign_exc=1 and misalign_addr=bj_pc, registered, next cycle, single pulse.
  - No redirect, no flush; state stays IDLE.
  - A not-taken branch with a misaligned target raises nothing.
- Aligned taken (T & ~M), in IDLE:
  - flush_if_id=1 combinationally in the same cycle.
  - redir_pc<=bj_pc; state->REQ next edge.
- REQ:
  - redir_valid=1 and flush_if_id=1 every cycle.
  - redir_pc stable until handshake.
  - Every ifu_rsp_valid is dropped (ifu_rsp_drop=ifu_rsp_valid).
- Handshake (REQ & redir_ready):
  - kill_cnt<=outst_next.
  - Next state: DRAIN if outst_next!=0, else IDLE.
  - redir_valid=0 the following cycle.
  - A request firing in the handshake cycle belongs to the old path and is counted.
- DRAIN:
  - ifu_rsp_drop=ifu_rsp_valid; kill_cnt decrements per response.
  - ->IDLE on the edge where kill_cnt goes 1->0.
  - Responses after that are new-path and pass through.
- IDLE: ifu_rsp_drop=0.
- Outstanding tracking: outst_next = outst + ifu_req_fire - ifu_rsp_valid, updated every cycle including dropped responses. Simultaneous req and rsp leave it unchanged.
- Protocol errors (checked by bench assertion; RTL not required to tolerate):
  - outst exceeding OUTST_MAX.
  - rsp with outst==0.
- REQ and DRAIN: EX-side events are ignored (the instruction is wrong-path and already flushed); counters do not advance.

Test Plan:
- Reset mid-REQ: taken bj_pc=0x8000_0100, hold redir_ready=0 3 cycles, pulse rst -> next cycle redir_valid=0, state IDLE, counters 0.
- Taken with no fetches outstanding: bj_pc=0x8000_0040, redir_ready=1 immediately -> flush_if_id in T cycle and REQ cycle, redir_pc=0x8000_0040 for 1 cycle, back to IDLE, taken_cnt=1, bj_cnt=1.
- Backpressure + drain: 2 requests outstanding, taken, redir_ready low 2 cycles then high with ifu_req_fire in the same cycle -> kill_cnt=3. Next 3 responses show ifu_rsp_drop=1, the 4th shows 0; IDLE after the 3rd.
- Misaligned JALR target 0x8000_0102 -> misalign_exc pulse 1 cycle with addr 0x8000_0102, no redir_valid, no flush, taken_cnt unchanged, bj_cnt+1.
- Not-taken BEQ (branch_jump=0), target 0x3 -> no exception, no flush; bj_cnt+1, taken_cnt unchanged.
- Ignore in REQ/DRAIN: ex_valid&ex_bj&branch_jump asserted during REQ and DRAIN -> no counter change, redir_pc unchanged.
- Counter wrap: preload/force taken_cnt=0xFFFF_FFFF, one aligned taken -> 0x0000_0000.
